pipe_hazard_ctrl: RTL

Central pipeline controller for the 5-stage processor.
- Drives enable and flush (bubble) controls for the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Handles load-use stalls, taken-branch flushes and multicycle EX operations (multiply).
- Keeps saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller state encoding
  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } ctrl_state_e;

  // Hard-wired zero register (x0); writes to it never create a dependency
  localparam int REG_ZERO = 0;

  // Default register-address width
  localparam int REG_W_DEF = 5;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count events, stopping at the maximum value instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : sat_counter

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: load-use stalls, branch flushes,
// multicycle EX stalls and saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // mc_cnt only ever holds values up to MC_LAT-2
  localparam int MCW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [MCW-1:0]   MC_LOAD = MCW'(MC_LAT - 2);
  localparam logic [REG_W-1:0] RD_ZERO = REG_W'(REG_ZERO);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_nxt;
  logic [MCW-1:0]   r_mc_cnt;
  logic [MCW-1:0]   w_mc_cnt_nxt;

  logic w_mc_hit;
  logic w_br_hit;
  logic w_lu_hit;

  logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_mc_busy;
  logic w_stall_inc, w_flush_inc;

  // Hazard detection; every EX-side hazard needs a real instruction in EX
  assign w_mc_hit = ex_valid & ex_mc_start;
  assign w_br_hit = ex_valid & ex_branch_taken;
  assign w_lu_hit = ex_valid & ex_is_load & id_valid & (ex_rd != RD_ZERO) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // State and multicycle countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_mc_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  // Next-state and pipeline controls; multicycle > branch > load-use
  always_comb begin
    w_state_nxt   = r_state;
    w_mc_cnt_nxt  = r_mc_cnt;
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_idex_en     = 1'b1;
    w_exmem_en    = 1'b1;
    w_memwb_en    = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_mc_busy     = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;

    unique case (r_state)
      RUN: begin
        if (w_mc_hit) begin
          // Freeze front end, bubble into MEM, let older work drain
          w_pc_en       = 1'b0;
          w_ifid_en     = 1'b0;
          w_idex_en     = 1'b0;
          w_exmem_flush = 1'b1;
          w_mc_busy     = 1'b1;
          w_stall_inc   = 1'b1;
          w_state_nxt   = MC_WAIT;
          w_mc_cnt_nxt  = MC_LOAD;
        end else if (w_br_hit) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_flush_inc  = 1'b1;
        end else if (w_lu_hit) begin
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
          w_stall_inc  = 1'b1;
        end
      end
      MC_WAIT: begin
        if (r_mc_cnt != '0) begin
          w_pc_en       = 1'b0;
          w_ifid_en     = 1'b0;
          w_idex_en     = 1'b0;
          w_exmem_flush = 1'b1;
          w_mc_busy     = 1'b1;
          w_stall_inc   = 1'b1;
          w_mc_cnt_nxt  = r_mc_cnt - 1'b1;
        end else begin
          // Release cycle: the op is still in EX with mc_start high, so
          // only branch and load-use are considered here
          w_state_nxt = RUN;
          if (w_br_hit) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_flush_inc  = 1'b1;
          end else if (w_lu_hit) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
            w_stall_inc  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt  = RUN;
        w_mc_cnt_nxt = '0;
      end
    endcase
  end

  // While reset is held every pipeline register is frozen
  assign pc_en       = rst_n & w_pc_en;
  assign ifid_en     = rst_n & w_ifid_en;
  assign idex_en     = rst_n & w_idex_en;
  assign exmem_en    = rst_n & w_exmem_en;
  assign memwb_en    = rst_n & w_memwb_en;
  assign ifid_flush  = rst_n & w_ifid_flush;
  assign idex_flush  = rst_n & w_idex_flush;
  assign exmem_flush = rst_n & w_exmem_flush;
  assign mc_busy     = rst_n & w_mc_busy;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

endmodule : pipe_hazard_ctrl
